// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM state type and helpers for the instruction fetch front end.
// FETCH_PERF_COUNT_EN (optional) enables the retired/taken performance counters.
package instruction_fetch_pkg;

    localparam int unsigned PC_WIDTH       = 8;
    localparam int unsigned INSN_WIDTH     = 9;
    localparam int unsigned DATA_WIDTH     = 8;
    localparam int unsigned BR_IMM_WIDTH   = 6;
    localparam int unsigned PERF_CNT_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0] START_ADDR = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_ISSUE,
        FETCH_HALTED
    } fsm_state_t;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + PERF_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// next_pc_calc: combinational next-PC selection (halt > jump > taken branch > sequential).
// All arithmetic wraps modulo 2^PC_WIDTH.
module next_pc_calc
    import instruction_fetch_pkg::*;
(
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic                  i_halt,
    input  logic                  i_branch,
    input  logic                  i_jump,
    input  logic                  i_relative,
    input  logic [DATA_WIDTH-1:0] i_destBranchJump,
    input  logic                  i_compareFlag,
    output logic [PC_WIDTH-1:0]   o_nextPc,
    output logic                  o_taken
);

    logic [PC_WIDTH-1:0] w_offset;
    logic [PC_WIDTH-1:0] w_target;

    assign w_offset = {{(PC_WIDTH-BR_IMM_WIDTH){i_destBranchJump[BR_IMM_WIDTH-1]}},
                       i_destBranchJump[BR_IMM_WIDTH-1:0]};

    assign w_target = i_relative ? (i_pc + w_offset) : i_destBranchJump[PC_WIDTH-1:0];

    always_comb begin
        o_taken  = 1'b0;
        o_nextPc = i_pc + PC_WIDTH'(1);
        if (i_halt) begin
            o_nextPc = i_pc;
        end else if (i_jump || (i_branch && i_compareFlag)) begin
            o_taken  = 1'b1;
            o_nextPc = w_target;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, requests ROM words and hands them to the decoder.
// Optional FETCH_PERF_COUNT_EN adds saturating retired/taken counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    output logic                      o_romReq,
    output logic [PC_WIDTH-1:0]       o_romAddr,
    input  logic                      i_romValid,
    input  logic [INSN_WIDTH-1:0]     i_romData,
    output logic [INSN_WIDTH-1:0]     o_instruction,
    output logic                      o_insnValid,
    input  logic                      i_halt,
    input  logic                      i_branch,
    input  logic                      i_jump,
    input  logic                      i_relative,
    input  logic [DATA_WIDTH-1:0]     i_destBranchJump,
    input  logic                      i_compareFlag,
    output logic [PC_WIDTH-1:0]       o_pc,
    output logic                      o_halted,
    output logic [PERF_CNT_WIDTH-1:0] o_retiredCount,
    output logic [PERF_CNT_WIDTH-1:0] o_takenCount
);

    fsm_state_t            r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [INSN_WIDTH-1:0] r_instruction;
    logic                  r_romReq;
    logic                  r_insnValid;
    logic                  r_halted;

    logic [PC_WIDTH-1:0]   w_nextPc;
    logic                  w_taken;

    next_pc_calc u_next_pc_calc (
        .i_pc             (r_pc),
        .i_halt           (i_halt),
        .i_branch         (i_branch),
        .i_jump           (i_jump),
        .i_relative       (i_relative),
        .i_destBranchJump (i_destBranchJump),
        .i_compareFlag    (i_compareFlag),
        .o_nextPc         (w_nextPc),
        .o_taken          (w_taken)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= FETCH_IDLE;
            r_pc          <= START_ADDR;
            r_instruction <= '0;
            r_romReq      <= 1'b0;
            r_insnValid   <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (i_start) begin
                        r_state  <= FETCH_REQ;
                        r_romReq <= 1'b1;
                    end
                end
                FETCH_REQ: begin
                    if (i_romValid) begin
                        r_instruction <= i_romData;
                        r_state       <= FETCH_ISSUE;
                        r_romReq      <= 1'b0;
                        r_insnValid   <= 1'b1;
                    end
                end
                FETCH_ISSUE: begin
                    r_insnValid <= 1'b0;
                    r_pc        <= w_nextPc;
                    if (i_halt) begin
                        r_state  <= FETCH_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= FETCH_REQ;
                        r_romReq <= 1'b1;
                    end
                end
                FETCH_HALTED: begin
                    if (i_start) begin
                        r_pc     <= START_ADDR;
                        r_state  <= FETCH_REQ;
                        r_halted <= 1'b0;
                        r_romReq <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign o_romReq      = r_romReq;
    assign o_romAddr     = r_pc;
    assign o_pc          = r_pc;
    assign o_instruction = r_instruction;
    assign o_insnValid   = r_insnValid;
    assign o_halted      = r_halted;

`ifdef FETCH_PERF_COUNT_EN
    logic [PERF_CNT_WIDTH-1:0] r_retiredCount;
    logic [PERF_CNT_WIDTH-1:0] r_takenCount;

    // Counters survive a restart; only reset clears them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_retiredCount <= '0;
            r_takenCount   <= '0;
        end else if (r_state == FETCH_ISSUE) begin
            r_retiredCount <= sat_inc(r_retiredCount);
            if (w_taken) begin
                r_takenCount <= sat_inc(r_takenCount);
            end
        end
    end

    assign o_retiredCount = r_retiredCount;
    assign o_takenCount   = r_takenCount;
`else
    logic w_unused_taken;
    assign w_unused_taken = w_taken;

    assign o_retiredCount = '0;
    assign o_takenCount   = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (with or without FETCH_PERF_COUNT_EN).
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic                      i_clk;
    logic                      i_reset;
    logic                      i_start;
    logic                      o_romReq;
    logic [PC_WIDTH-1:0]       o_romAddr;
    logic                      i_romValid;
    logic [INSN_WIDTH-1:0]     i_romData;
    logic [INSN_WIDTH-1:0]     o_instruction;
    logic                      o_insnValid;
    logic                      i_halt;
    logic                      i_branch;
    logic                      i_jump;
    logic                      i_relative;
    logic [DATA_WIDTH-1:0]     i_destBranchJump;
    logic                      i_compareFlag;
    logic [PC_WIDTH-1:0]       o_pc;
    logic                      o_halted;
    logic [PERF_CNT_WIDTH-1:0] o_retiredCount;
    logic [PERF_CNT_WIDTH-1:0] o_takenCount;

    int checks;
    int errors;
    logic [PC_WIDTH-1:0] m_pc;

    instruction_fetch u_dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .o_romReq         (o_romReq),
        .o_romAddr        (o_romAddr),
        .i_romValid       (i_romValid),
        .i_romData        (i_romData),
        .o_instruction    (o_instruction),
        .o_insnValid      (o_insnValid),
        .i_halt           (i_halt),
        .i_branch         (i_branch),
        .i_jump           (i_jump),
        .i_relative       (i_relative),
        .i_destBranchJump (i_destBranchJump),
        .i_compareFlag    (i_compareFlag),
        .o_pc             (o_pc),
        .o_halted         (o_halted),
        .o_retiredCount   (o_retiredCount),
        .o_takenCount     (o_takenCount)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSN_WIDTH-1:0] rom_word(input logic [PC_WIDTH-1:0] a);
        if (a == '0) begin
            return '0;
        end
        return INSN_WIDTH'((32'(a) * 37 + 5) % 512);
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Entered in REQ; serves the word at m_pc, drives decoder outputs in ISSUE.
    task automatic issue(input string tag, input logic h, input logic b, input logic j,
                         input logic r, input logic [7:0] dest, input logic f,
                         input logic [7:0] exp_next);
        i_romData  = rom_word(m_pc);
        i_romValid = 1'b1;
        step();
        check_val({tag, "_valid"}, 32'(o_insnValid), 32'd1);
        check_val({tag, "_insn"}, 32'(o_instruction), 32'(rom_word(m_pc)));
        i_halt           = h;
        i_branch         = b;
        i_jump           = j;
        i_relative       = r;
        i_destBranchJump = dest;
        i_compareFlag    = f;
        step();
        i_halt           = 1'b0;
        i_branch         = 1'b0;
        i_jump           = 1'b0;
        i_relative       = 1'b0;
        i_destBranchJump = '0;
        i_compareFlag    = 1'b0;
        check_val({tag, "_pc"}, 32'(o_pc), 32'(exp_next));
        m_pc = exp_next;
    endtask

    task automatic check_counters(input string tag, input int retired, input int taken);
`ifdef FETCH_PERF_COUNT_EN
        check_val({tag, "_retired"}, 32'(o_retiredCount), 32'(retired));
        check_val({tag, "_taken"}, 32'(o_takenCount), 32'(taken));
`else
        check_val({tag, "_retired_tied"}, 32'(o_retiredCount), 32'd0 * 32'(retired));
        check_val({tag, "_taken_tied"}, 32'(o_takenCount), 32'd0 * 32'(taken));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks           = 0;
        errors           = 0;
        m_pc             = '0;
        i_reset          = 1'b1;
        i_start          = 1'b0;
        i_romValid       = 1'b0;
        i_romData        = '0;
        i_halt           = 1'b0;
        i_branch         = 1'b0;
        i_jump           = 1'b0;
        i_relative       = 1'b0;
        i_destBranchJump = '0;
        i_compareFlag    = 1'b0;

        repeat (2) @(posedge i_clk);
        #1;
        check_val("rst_pc", 32'(o_pc), 32'd0);
        check_val("rst_req", 32'(o_romReq), 32'd0);
        check_val("rst_valid", 32'(o_insnValid), 32'd0);
        check_val("rst_halted", 32'(o_halted), 32'd0);
        check_val("rst_insn", 32'(o_instruction), 32'd0);
        check_counters("rst", 0, 0);

        i_reset = 1'b0;
        step();
        check_val("idle_req", 32'(o_romReq), 32'd0);

        // Sequential fetch from address 0, zero-wait ROM.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_val("start_req", 32'(o_romReq), 32'd1);
        check_val("start_addr", 32'(o_romAddr), 32'd0);
        check_val("start_valid", 32'(o_insnValid), 32'd0);
        issue("seq0", 0, 0, 0, 0, 8'h00, 0, 8'h01);
        check_val("seq0_req", 32'(o_romReq), 32'd1);
        check_val("seq0_addr", 32'(o_romAddr), 32'd1);
        issue("seq1", 0, 0, 0, 0, 8'h00, 0, 8'h02);
        issue("jmp5", 0, 0, 1, 0, 8'h05, 0, 8'h05);

        // ROM stalls 3 cycles at pc=5; a stray start in REQ must not matter.
        i_romValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val("wait_req", 32'(o_romReq), 32'd1);
            check_val("wait_addr", 32'(o_romAddr), 32'd5);
            check_val("wait_valid", 32'(o_insnValid), 32'd0);
            i_start = (k == 1);
            step();
            i_start = 1'b0;
        end
        check_val("wait_req4", 32'(o_romReq), 32'd1);
        check_val("wait_addr4", 32'(o_romAddr), 32'd5);
        issue("wait5", 0, 0, 0, 0, 8'h00, 0, 8'h06);
        check_val("wait_single_pulse", 32'(o_insnValid), 32'd0);

        issue("jmp10a", 0, 0, 1, 0, 8'h10, 0, 8'h10);
        issue("br_taken", 0, 1, 0, 1, 8'h3C, 1, 8'h0C);
        issue("jmp10b", 0, 0, 1, 0, 8'h10, 0, 8'h10);
        issue("br_not", 0, 1, 0, 1, 8'h3C, 0, 8'h11);
        issue("jmp02", 0, 0, 1, 0, 8'h02, 0, 8'h02);
        issue("jmp_f0", 0, 0, 1, 0, 8'hF0, 0, 8'hF0);
        issue("jmp_ff", 0, 0, 1, 0, 8'hFF, 0, 8'hFF);
        issue("wrap_seq", 0, 0, 0, 0, 8'h00, 0, 8'h00);
        issue("br_wrap", 0, 1, 0, 1, 8'h3C, 1, 8'hFC);
        issue("jmp07", 0, 0, 1, 0, 8'h07, 0, 8'h07);
        // Halt outranks a simultaneous jump.
        issue("halt", 1, 0, 1, 0, 8'h55, 0, 8'h07);
        check_val("halt_halted", 32'(o_halted), 32'd1);
        check_val("halt_req", 32'(o_romReq), 32'd0);
        check_val("halt_valid", 32'(o_insnValid), 32'd0);

        i_jump           = 1'b1;
        i_destBranchJump = 8'h40;
        repeat (2) step();
        i_jump           = 1'b0;
        i_destBranchJump = '0;
        check_val("halted_hold_pc", 32'(o_pc), 32'd7);
        check_val("halted_hold", 32'(o_halted), 32'd1);
        check_val("halted_hold_req", 32'(o_romReq), 32'd0);
        check_counters("run", 15, 9);

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        m_pc    = '0;
        check_val("restart_pc", 32'(o_pc), 32'd0);
        check_val("restart_req", 32'(o_romReq), 32'd1);
        check_val("restart_halted", 32'(o_halted), 32'd0);
        check_counters("restart", 15, 9);

        // Async reset in the middle of a stalled request.
        issue("jmp22", 0, 0, 1, 0, 8'h22, 0, 8'h22);
        i_romValid = 1'b0;
        step();
        check_val("pre_rst_req", 32'(o_romReq), 32'd1);
        check_val("pre_rst_pc", 32'(o_pc), 32'd34);
        #2;
        i_reset = 1'b1;
        #1;
        check_val("async_rst_req", 32'(o_romReq), 32'd0);
        check_val("async_rst_pc", 32'(o_pc), 32'd0);
        check_val("async_rst_halted", 32'(o_halted), 32'd0);
        step();
        i_reset    = 1'b0;
        i_romValid = 1'b1;
        m_pc       = '0;
        step();
        check_val("post_rst_idle", 32'(o_romReq), 32'd0);
        check_counters("post_rst", 0, 0);

        // Four instructions with one taken jump, ending in halt.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        issue("p_seq0", 0, 0, 0, 0, 8'h00, 0, 8'h01);
        issue("p_jmp", 0, 0, 1, 0, 8'h30, 0, 8'h30);
        issue("p_seq1", 0, 0, 0, 0, 8'h00, 0, 8'h31);
        issue("p_halt", 1, 0, 0, 0, 8'h00, 0, 8'h31);
        check_val("p_halted", 32'(o_halted), 32'd1);
        check_counters("perf", 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front end of the core. Owns the program counter and issues read requests to instruction ROM over a valid-qualified request/response interface.
- Presents each fetched word to the instruction decoder with a one-cycle valid strobe.
- Consumes the decoder's halt/branch/jump/relative/destBranchJump outputs in that same cycle to pick the next PC.
- Sits between instruction ROM and the control unit; it is the producer end of the decoder's instruction interface.

Parameters:
- PC_WIDTH, 8, program counter and ROM address width.
- INSN_WIDTH, 9, instruction word width (package INSN_WIDTH).
- BR_IMM_WIDTH, 6, significant low bits of destBranchJump used as the signed relative offset.
- START_ADDR, 0, PC value after reset and after a restart.

Ports:
- _clk  input  1  clock, rising edge.
- _reset  input  1  asynchronous active-high reset.
- _start  input  1  single-cycle pulse; leaves IDLE or HALTED.
- romReq  output  1  ROM read request.
- romAddr  output  PC_WIDTH  ROM read address; equals pc.
- _romValid  input  1  ROM data valid.
- _romData  input  INSN_WIDTH  ROM read data.
- instruction  output  INSN_WIDTH  registered instruction to the decoder.
- insnValid  output  1  instruction is live this cycle.
- _halt, _branch, _jump, _relative  input  1 each  decoder outputs, sampled only while insnValid=1.
- _destBranchJump  input  DATA_WIDTH  decoder target field.
- _compareFlag  input  1  stored comparison result; qualifies a branch.
- pc  output  PC_WIDTH  current program counter.
- halted  output  1  state == HALTED.
- retiredCount, takenCount  output  16 each  performance counters (see Optional Feature).

Behaviour:
- Reset: state=IDLE, pc=START_ADDR, instruction=0, all outputs 0. Reset is async, so romReq drops in the same cycle reset asserts, including mid-REQ or mid-ISSUE. Any in-flight ROM response is discarded.
- States: IDLE, REQ, ISSUE, HALTED (fsm_state_t enum).
- IDLE: romReq=0. _start moves to REQ.
- REQ: romReq=1, romAddr=pc.
  - _romValid=1 (same cycle allowed) registers _romData into instruction and moves to ISSUE.
  - Otherwise stay in REQ, holding romReq and romAddr stable.
  - _start is ignored.
- ISSUE: insnValid=1 for exactly one cycle. Next pc, by priority:
  1. _halt: pc unchanged, state goes to HALTED.
  2. _jump: pc = target.
  3. _branch && _compareFlag: pc = target.
  4. _branch && !_compareFlag: pc + 1.
  5. otherwise: pc + 1.
  - Except on halt, state returns to REQ.
- Target computation:
  - _relative=1: pc + sign-extended _destBranchJump[BR_IMM_WIDTH-1:0].
  - _relative=0: _destBranchJump[PC_WIDTH-1:0].
- All PC arithmetic is modulo 2^PC_WIDTH. pc + 1 at all-ones wraps to 0; a relative target may also wrap either direction.
- HALTED: halted=1, romReq=0, pc holds the halt instruction's address. _start sets pc=START_ADDR and moves to REQ. Only _start or _reset leave HALTED.
- Throughput: 2 cycles per instruction with a zero-wait ROM; each ROM wait cycle adds 1.
- _start in REQ or ISSUE has no effect. Decoder inputs outside ISSUE are ignored.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined:
  - retiredCount increments on every ISSUE cycle, including the halt instruction.
  - takenCount increments on a taken jump or branch.
  - Both are 16-bit, saturate at 0xFFFF, clear on reset, and are not cleared by _start.
- Undefined: both ports are present and tied to 0; no counter flops exist.

Decomposition:
- Add to package definitions: fsm_state_t enum (FETCH_IDLE, FETCH_REQ, FETCH_ISSUE, FETCH_HALTED), PC_WIDTH, BR_IMM_WIDTH, START_ADDR, PERF_CNT_WIDTH=16.
- One sub-module, next_pc_calc: combinational next-PC/target logic covering priority, sign-extension and wrap. It is unit-testable on its own.
- Counters stay inline under the macro.

Test Plan:
- Reset, _start, ROM returns 0x000 at addr 0 with zero wait -> romReq rises the cycle after _start, insnValid pulses 2 cycles later, pc sequence 0,1,2.
- ROM valid delayed 3 cycles at pc=5 -> romReq and romAddr=5 held for 4 cycles, one insnValid pulse, then pc=6.
- ISSUE at pc=0x10 with _branch=1, _relative=1, dest[5:0]=0x3C (-4), _compareFlag=1 -> pc=0x0C. Same with _compareFlag=0 -> pc=0x11.
- Absolute jump dest=0xF0 at pc=0x02 -> pc=0xF0. Sequential fetch at pc=0xFF -> pc wraps to 0x00.
- _halt in ISSUE at pc=0x07 -> halted=1, romReq=0, pc stays 0x07. _start -> pc=0x00 and fetch resumes.
- Assert _reset mid-REQ at pc=0x22 -> romReq=0 in the same cycle, pc=0, state IDLE.
- With FETCH_PERF_COUNT_EN: 4 instructions including one taken jump then halt -> retiredCount=4, takenCount=1.
